// File: rtl/ryu_pkg.sv
// Shared types and constants for the Ryu character controller.
// State encodings double as sprite codes, so sprite is the state register itself.
package ryu_pkg;

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_PUNCH  = 3'd1,
    ST_JUMP   = 3'd2,
    ST_CROUCH = 3'd3,
    ST_WALK_L = 3'd4,
    ST_WALK_R = 3'd5
  } state_t;

  localparam logic [2:0] SPR_STAND  = 3'd0;
  localparam logic [2:0] SPR_PUNCH  = 3'd1;
  localparam logic [2:0] SPR_JUMP   = 3'd2;
  localparam logic [2:0] SPR_CROUCH = 3'd3;
  localparam logic [2:0] SPR_LEFT   = 3'd4;
  localparam logic [2:0] SPR_RIGHT  = 3'd5;

  localparam logic [7:0] KEY_J = 8'h0D;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef logic signed [10:0] vel_t;

endpackage

// File: rtl/ryu_key_decode.sv
// Combinational decode of the two held USB HID keycodes into action flags.
// A key counts as held if it appears in either keycode slot.
module ryu_key_decode
  import ryu_pkg::*;
(
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic       punch,
  output logic       jump,
  output logic       crouch,
  output logic       left,
  output logic       right
);

  localparam logic [7:0] KEY_MAP [5] = '{KEY_J, KEY_W, KEY_S, KEY_A, KEY_D};

  logic [4:0] hit;

  for (genvar gi = 0; gi < 5; gi++) begin : g_key
    assign hit[gi] = (keycode0 == KEY_MAP[gi]) || (keycode1 == KEY_MAP[gi]);
  end

  assign punch  = hit[0];
  assign jump   = hit[1];
  assign crouch = hit[2];
  assign left   = hit[3];
  assign right  = hit[4];

endmodule

// File: rtl/ryu_controller.sv
// Per-frame Ryu character controller: action FSM, jump physics and X clamping.
// Every register advances only on frame_tick cycles.
module ryu_controller
  import ryu_pkg::*;
#(
  parameter int X_START      = 100,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 576,
  parameter int GROUND_Y     = 300,
  parameter int STEP         = 2,
  parameter int JUMP_V       = 12,
  parameter int GRAVITY      = 1,
  parameter int PUNCH_FRAMES = 8
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic [2:0] sprite
);

  localparam int PW = $clog2(PUNCH_FRAMES + 1);

  state_t            state_reg, state_next;
  logic [9:0]        x_reg, x_next;
  logic [9:0]        y_reg, y_next;
  vel_t              vy_reg, vy_next;
  logic signed [1:0] hdir_reg, hdir_next;
  logic [PW-1:0]     pcnt_reg, pcnt_next;
  vel_t              ny;
  logic              decide;
  logic              k_punch, k_jump, k_crouch, k_left, k_right;

  ryu_key_decode u_key_decode (
    .keycode0 (keycode0),
    .keycode1 (keycode1),
    .punch    (k_punch),
    .jump     (k_jump),
    .crouch   (k_crouch),
    .left     (k_left),
    .right    (k_right)
  );

  // Horizontal move by dir*STEP, saturating into [X_MIN, X_MAX].
  function automatic logic [9:0] move_x(input logic [9:0] x, input logic signed [1:0] dir);
    int xi;
    xi = int'(x) + int'(dir) * STEP;
    if (xi < X_MIN)      xi = X_MIN;
    else if (xi > X_MAX) xi = X_MAX;
    return 10'(xi);
  endfunction

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_reg <= ST_STAND;
      x_reg     <= 10'(X_START);
      y_reg     <= 10'(GROUND_Y);
      vy_reg    <= '0;
      hdir_reg  <= '0;
      pcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      vy_reg    <= vy_next;
      hdir_reg  <= hdir_next;
      pcnt_reg  <= pcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    vy_next    = vy_reg;
    hdir_next  = hdir_reg;
    pcnt_next  = pcnt_reg;
    ny         = vel_t'({1'b0, y_reg}) + vy_reg;
    decide     = 1'b0;

    if (frame_tick) begin
      case (state_reg)
        ST_PUNCH: begin
          if (pcnt_reg == '0) decide = 1'b1;
          else                pcnt_next = pcnt_reg - 1'b1;
        end
        ST_JUMP: begin
          vy_next = vy_reg + vel_t'(GRAVITY);
          x_next  = move_x(x_reg, hdir_reg);
          if (ny >= vel_t'(GROUND_Y)) begin
            y_next     = 10'(GROUND_Y);
            vy_next    = '0;
            state_next = ST_STAND;
          end else if (ny[10]) begin
            y_next = '0;
          end else begin
            y_next = ny[9:0];
          end
        end
        default: decide = 1'b1;
      endcase
    end

    // Grounded priority decision: punch > jump > crouch > left > right > stand.
    if (decide) begin
      if (k_punch) begin
        state_next = ST_PUNCH;
        pcnt_next  = PW'(PUNCH_FRAMES - 1);
      end else if (k_jump) begin
        state_next = ST_JUMP;
        vy_next    = -vel_t'(JUMP_V);
        hdir_next  = k_left ? 2'sb11 : (k_right ? 2'sb01 : 2'sb00);
      end else if (k_crouch) begin
        state_next = ST_CROUCH;
      end else if (k_left) begin
        state_next = ST_WALK_L;
        x_next     = move_x(x_reg, 2'sb11);
      end else if (k_right) begin
        state_next = ST_WALK_R;
        x_next     = move_x(x_reg, 2'sb01);
      end else begin
        state_next = ST_STAND;
      end
    end
  end

  assign RyuX   = x_reg;
  assign RyuY   = y_reg;
  assign sprite = state_reg;

endmodule
